// File: rtl/guess_game_ctrl.sv
// Round sequencer for the button/guess game: countdown, attempt detection, tries and result hold.
// Optional RETRY_TIMER_EN: every non-final wrong guess restarts the round timer.
module guess_game_ctrl #(
    parameter int unsigned DATA_W         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 150000000,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned RESULT_CYCLES  = 50000000
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               button,
    input  logic [DATA_W-1:0]                  guess,
    input  logic [DATA_W-1:0]                  secret,
    output logic [1:0]                         out,
    output logic [$clog2(MAX_TRIES+1)-1:0]     tries_left,
    output logic                               seg3_tick
);

    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RES_W = $clog2(RESULT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_PLAY = 2'b01;
    localparam logic [1:0] ST_WIN  = 2'b10;
    localparam logic [1:0] ST_LOSE = 2'b11;

    logic [1:0]       state_nx;
    logic [TRY_W-1:0] tries_nx;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_nx;
    logic [RES_W-1:0] res_cnt;
    logic [RES_W-1:0] res_nx;
    logic             tick_nx;
    logic             button_q;
    logic             attempt_c;
    logic             match_c;

    assign attempt_c = button & ~button_q;
    assign match_c   = (guess == secret);

    // State code doubles as the out register.
    always_ff @(posedge clk) begin
        if (reset) begin
            out        <= ST_IDLE;
            tries_left <= '0;
            timer      <= '0;
            res_cnt    <= '0;
            seg3_tick  <= 1'b0;
            button_q   <= 1'b0;
        end else begin
            out        <= state_nx;
            tries_left <= tries_nx;
            timer      <= timer_nx;
            res_cnt    <= res_nx;
            seg3_tick  <= tick_nx;
            button_q   <= button;
        end
    end

    always_comb begin
        state_nx = out;
        tries_nx = tries_left;
        timer_nx = timer;
        res_nx   = res_cnt;
        tick_nx  = 1'b0;
        case (out)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_PLAY;
                    tries_nx = TRY_W'(MAX_TRIES);
                    timer_nx = TMR_W'(TIMEOUT_CYCLES - 1);
                end
            end
            ST_PLAY: begin
                if (attempt_c && match_c) begin
                    state_nx = ST_WIN;
                    res_nx   = RES_W'(RESULT_CYCLES - 1);
                end else if (attempt_c) begin
                    if (tries_left == TRY_W'(1)) begin
                        state_nx = ST_LOSE;
                        tries_nx = '0;
                        res_nx   = RES_W'(RESULT_CYCLES - 1);
                    end else begin
                        tries_nx = tries_left - TRY_W'(1);
`ifdef RETRY_TIMER_EN
                        timer_nx = TMR_W'(TIMEOUT_CYCLES - 1);
`else
                        // Hold at zero so the timeout still fires on the following edge.
                        timer_nx = (timer == '0) ? timer : timer - TMR_W'(1);
`endif
                    end
                end else if (timer == '0) begin
                    state_nx = ST_LOSE;
                    tick_nx  = 1'b1;
                    res_nx   = RES_W'(RESULT_CYCLES - 1);
                end else begin
                    timer_nx = timer - TMR_W'(1);
                end
            end
            default: begin
                if (res_cnt == '0) begin
                    state_nx = ST_IDLE;
                end else begin
                    res_nx = res_cnt - RES_W'(1);
                end
            end
        endcase
    end

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed plus random stimulus for guess_game_ctrl, checked every cycle against a deadline-based model.
module tb_guess_game_ctrl;

    localparam int unsigned DW = 4;
    localparam int unsigned T  = 8;
    localparam int unsigned MT = 3;
    localparam int unsigned R  = 4;
    localparam int unsigned TW = $clog2(MT + 1);

    logic          clk = 1'b0;
    logic          reset, start, button;
    logic [DW-1:0] guess, secret;
    logic [1:0]    out;
    logic [TW-1:0] tries_left;
    logic          seg3_tick;

    always #5 clk = ~clk;

    guess_game_ctrl #(
        .DATA_W(DW), .TIMEOUT_CYCLES(T), .MAX_TRIES(MT), .RESULT_CYCLES(R)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .button(button),
        .guess(guess), .secret(secret), .out(out),
        .tries_left(tries_left), .seg3_tick(seg3_tick)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: mode 0 idle, 1 play, 2 win, 3 lose; timeouts and result ends as absolute edge numbers.
    int m_mode = 0;
    int m_tries = 0;
    int m_deadline = 0;
    int m_leave = 0;
    bit m_tick = 1'b0;
    bit m_prev_btn = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit att;
        cyc++;
        att = button && !m_prev_btn;
        m_prev_btn = button;
        m_tick = 1'b0;
        if (reset) begin
            m_mode = 0;
            m_tries = 0;
            m_prev_btn = 1'b0;
        end else begin
            case (m_mode)
                0: if (start) begin
                    m_mode = 1;
                    m_tries = MT;
                    m_deadline = cyc + T;
                end
                1: begin
                    if (att && guess == secret) begin
                        m_mode = 2;
                        m_leave = cyc + R;
                    end else if (att) begin
                        if (m_tries == 1) begin
                            m_mode = 3;
                            m_tries = 0;
                            m_leave = cyc + R;
                        end else begin
                            m_tries--;
`ifdef RETRY_TIMER_EN
                            m_deadline = cyc + T;
`else
                            if (cyc == m_deadline) m_deadline = cyc + 1;
`endif
                        end
                    end else if (cyc == m_deadline) begin
                        m_mode = 3;
                        m_tick = 1'b1;
                        m_leave = cyc + R;
                    end
                end
                default: if (cyc == m_leave) m_mode = 0;
            endcase
        end
    endtask

    task automatic step(input bit r, input bit s, input bit b, input logic [DW-1:0] g);
        @(negedge clk);
        reset = r; start = s; button = b; guess = g;
        @(posedge clk);
        model_edge();
        #1;
        check("out", 32'(out), 32'(m_mode));
        check("tries_left", 32'(tries_left), 32'(m_tries));
        check("seg3_tick", 32'(seg3_tick), 32'(m_tick));
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; button = 1'b0; guess = '0; secret = 4'd5;

        // Reset, then an untouched round that times out.
        step(1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b1, 1'b0, 4'd0);
        idle_steps(13);

        // Correct guess early in the round.
        step(1'b0, 1'b1, 1'b0, 4'd0);
        idle_steps(2);
        step(1'b0, 1'b0, 1'b1, 4'd5);
        idle_steps(6);

        // Three wrong guesses exhaust the tries.
        step(1'b0, 1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b1, 4'd2);
        step(1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b1, 4'd7);
        step(1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b1, 4'd9);
        idle_steps(6);

        // Held button counts once.
        step(1'b0, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 4'd3);
        idle_steps(10);

        // Correct guess on the timeout edge.
        step(1'b0, 1'b1, 1'b0, 4'd0);
        idle_steps(7);
        step(1'b0, 1'b0, 1'b1, 4'd5);
        idle_steps(6);

        // Wrong guess at cycle 6 of the round.
        step(1'b0, 1'b1, 1'b0, 4'd0);
        idle_steps(5);
        step(1'b0, 1'b0, 1'b1, 4'd1);
        idle_steps(16);

        // Reset mid-round with one try left, then a fresh round.
        step(1'b0, 1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b1, 4'd1);
        step(1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b1, 4'd1);
        step(1'b1, 1'b0, 1'b1, 4'd0);
        step(1'b0, 1'b1, 1'b1, 4'd0);
        idle_steps(3);

        // Start held through a result.
        step(1'b0, 1'b1, 1'b1, 4'd5);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 4'd5);

        for (int i = 0; i < 3000; i++) begin
            bit r, s, b;
            logic [DW-1:0] g;
            if (i % 256 == 0) secret = DW'($urandom);
            r = ($urandom_range(0, 99) == 0);
            s = ($urandom_range(0, 3) == 0);
            if ((i / 200) % 2 == 1) b = 1'($urandom_range(0, 1));
            else                    b = ($urandom_range(0, 9) == 0);
            g = ($urandom_range(0, 3) == 0) ? secret : DW'($urandom);
            step(r, s, b, g);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
